// File: rtl/mmio_uart_tx_if.sv
// Data-memory bus as seen by an MMIO responder: address, write strobe/mask/data, read data.
interface mmio_uart_tx_if;
    logic [31:0] a;
    logic        we;
    logic [3:0]  wmask;
    logic [31:0] wd;
    logic [31:0] rd;

    modport master (output a, output we, output wmask, output wd, input rd);
    modport slave  (input a, input we, input wmask, input wd, output rd);
endinterface

// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 UART transmitter: TX FIFO, status/divisor registers, serializer.
module mmio_uart_tx #(
    parameter logic [31:0] BASE_ADDR   = 32'h1000_0000,
    parameter int unsigned DEPTH       = 8,
    parameter logic [15:0] DEFAULT_DIV = 16'd868
) (
    input  logic         clk,
    input  logic         reset,
    mmio_uart_tx_if.slave bus,
    output logic         tx
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;
    localparam int unsigned DIV_W = 16;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_STOP
    } state_t;

    // Address decode and register strobes
    logic       sel;
    logic [1:0] offset;
    logic       wr_txdata;
    logic       wr_status;
    logic       wr_div;

    assign sel       = (bus.a[31:4] == BASE_ADDR[31:4]);
    assign offset    = bus.a[3:2];
    assign wr_txdata = sel && bus.we && (offset == 2'd0) && bus.wmask[0];
    assign wr_status = sel && bus.we && (offset == 2'd1);
    assign wr_div    = sel && bus.we && (offset == 2'd2);

    // Bits of the bus this block never looks at
    logic unused_bits;
    assign unused_bits = ^{bus.a[1:0], bus.wd[31:16], bus.wmask[3:2]};

    // FIFO and control registers
    logic [7:0]       mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic             overflow;
    logic [DIV_W-1:0] divisor;

    logic full;
    logic empty;
    logic push_ok;
    logic pop;

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign push_ok = wr_txdata && (!full || pop);

    // Serializer state
    state_t           state;
    state_t           state_d;
    logic [7:0]       shift;
    logic [7:0]       shift_d;
    logic [DIV_W-1:0] timer;
    logic [DIV_W-1:0] timer_d;
    logic [2:0]       bit_idx;
    logic [2:0]       bit_idx_d;
    logic [DIV_W-1:0] eff_div;
    logic [DIV_W-1:0] eff_div_d;
    logic             tx_d;
    logic             bit_end;
    logic             busy;

    assign bit_end = (timer == (eff_div - DIV_W'(1)));
    assign busy    = (state != ST_IDLE);

    // Read mux: zero outside the window and at unmapped offsets
    always_comb begin
        bus.rd = '0;
        if (sel) begin
            case (offset)
                2'd1:    bus.rd = {20'd0, 4'(count), 4'd0, overflow, busy, empty, full};
                2'd2:    bus.rd = {16'd0, divisor};
                default: bus.rd = '0;
            endcase
        end
    end

    // FIFO storage; contents need no reset since pointers define validity
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= bus.wd[7:0];
        end
    end

    // FIFO pointers, occupancy, sticky overflow and divisor register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
            divisor  <= DEFAULT_DIV;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            if (push_ok && !pop) begin
                count <= count + CNT_W'(1);
            end else if (!push_ok && pop) begin
                count <= count - CNT_W'(1);
            end
            if (wr_txdata && !push_ok) begin
                overflow <= 1'b1;
            end else if (wr_status && bus.wmask[0] && bus.wd[3]) begin
                overflow <= 1'b0;
            end
            if (wr_div && bus.wmask[0]) begin
                divisor[7:0] <= bus.wd[7:0];
            end
            if (wr_div && bus.wmask[1]) begin
                divisor[15:8] <= bus.wd[15:8];
            end
        end
    end

    // Serializer state register; tx is a flop so the line never glitches
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= ST_IDLE;
            shift   <= '0;
            timer   <= '0;
            bit_idx <= '0;
            eff_div <= DIV_W'(1);
            tx      <= 1'b1;
        end else begin
            state   <= state_d;
            shift   <= shift_d;
            timer   <= timer_d;
            bit_idx <= bit_idx_d;
            eff_div <= eff_div_d;
            tx      <= tx_d;
        end
    end

    // Serializer next-state: divisor is latched per frame, tx follows the next state
    always_comb begin
        state_d   = state;
        shift_d   = shift;
        timer_d   = timer;
        bit_idx_d = bit_idx;
        eff_div_d = eff_div;
        pop       = 1'b0;
        tx_d      = 1'b1;

        case (state)
            ST_IDLE: begin
                if (!empty) begin
                    pop       = 1'b1;
                    shift_d   = mem[rd_ptr];
                    eff_div_d = (divisor == '0) ? DIV_W'(1) : divisor;
                    timer_d   = '0;
                    state_d   = ST_START;
                end
            end
            ST_START: begin
                if (bit_end) begin
                    timer_d   = '0;
                    bit_idx_d = '0;
                    state_d   = ST_DATA;
                end else begin
                    timer_d = timer + DIV_W'(1);
                end
            end
            ST_DATA: begin
                if (bit_end) begin
                    timer_d = '0;
                    shift_d = shift >> 1;
                    if (bit_idx == 3'd7) begin
                        state_d = ST_STOP;
                    end else begin
                        bit_idx_d = bit_idx + 3'd1;
                    end
                end else begin
                    timer_d = timer + DIV_W'(1);
                end
            end
            ST_STOP: begin
                if (bit_end) begin
                    timer_d = '0;
                    state_d = ST_IDLE;
                end else begin
                    timer_d = timer + DIV_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase

        case (state_d)
            ST_START: tx_d = 1'b0;
            ST_DATA:  tx_d = shift_d[0];
            default:  tx_d = 1'b1;
        endcase
    end

endmodule
